// File: rtl/data_mem_bytelane.sv
// Byte-lane addressable data memory for the MEM stage of the MIPS datapath.
// Supports byte, halfword and word loads/stores with sign/zero extension,
// a registered read path with a valid strobe, error flagging for misaligned
// and out-of-range accesses, and a hardware clear sequence after reset.

module data_mem_bytelane #(
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int IDX_WIDTH  = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [31:0]           Write_data,
  input  logic [1:0]            Size,
  input  logic                  Unsigned,
  output logic [31:0]           Read_data,
  output logic                  rd_valid,
  output logic                  busy,
  output logic                  mem_err
);

  localparam logic [IDX_WIDTH-1:0] LastIdx = IDX_WIDTH'(DEPTH - 1);

  localparam logic [1:0] SizeByte = 2'b00;
  localparam logic [1:0] SizeHalf = 2'b01;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  // Storage: one 32-bit word per entry, written one byte lane at a time.
  logic [31:0] mem [DEPTH];

  // Control and output registers.
  state_t               state_q;
  logic [IDX_WIDTH-1:0] clrCnt_q;
  logic [IDX_WIDTH-1:0] clrCnt_d;
  logic                 busy_q;
  logic [31:0]          readData_q;
  logic [31:0]          readData_d;
  logic                 rdValid_q;
  logic                 memErr_q;

  // Address decode.
  logic [IDX_WIDTH-1:0] wordIdx;
  logic [1:0]           byteOff;
  logic                 outOfRange;
  logic                 misaligned;

  // Request qualification.
  logic accessReq;
  logic accessBad;
  logic accessLegal;
  logic readOk;
  logic writeOk;
  logic clearing;

  // Write port.
  logic [3:0]           laneEn;
  logic [31:0]          laneData;
  logic [IDX_WIDTH-1:0] memWrIdx;
  logic [3:0]           memWrLanes;
  logic [31:0]          memWrData;

  // Read extraction.
  logic [31:0] storedWord;
  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  assign wordIdx = address[IDX_WIDTH+1:2];
  assign byteOff = address[1:0];

  // Any set bit above the word index means the byte address lies past the array.
  generate
    if (ADDR_WIDTH > IDX_WIDTH + 2) begin : g_range
      assign outOfRange = |address[ADDR_WIDTH-1:IDX_WIDTH+2];
    end else begin : g_norange
      assign outOfRange = 1'b0;
    end
  endgenerate

  // Alignment rule: halves need an even address, words (and reserved size) need a multiple of four.
  always_comb begin
    misaligned = 1'b0;
    case (Size)
      SizeByte: misaligned = 1'b0;
      SizeHalf: misaligned = address[0];
      default:  misaligned = |address[1:0];
    endcase
  end

  // A request only counts while idle and out of reset; the clear sequence drops it silently.
  assign accessReq   = !rst && (state_q == IDLE) && !busy_q && (MemRead || MemWrite);
  assign accessLegal = !outOfRange && !misaligned;
  assign accessBad   = accessReq && !accessLegal;
  assign readOk      = accessReq && accessLegal && MemRead;
  assign writeOk     = accessReq && accessLegal && MemWrite;
  assign clearing    = !rst && (state_q == CLEAR);

  // Lane enables and lane-replicated store data, so each lane picks up the right bits.
  always_comb begin
    laneEn   = 4'b1111;
    laneData = Write_data;
    case (Size)
      SizeByte: begin
        laneEn   = 4'b0001 << byteOff;
        laneData = {4{Write_data[7:0]}};
      end
      SizeHalf: begin
        laneEn   = address[1] ? 4'b1100 : 4'b0011;
        laneData = {2{Write_data[15:0]}};
      end
      default: begin
        laneEn   = 4'b1111;
        laneData = Write_data;
      end
    endcase
  end

  // The single write port is shared: the clear sequence owns it until the array is zeroed.
  always_comb begin
    memWrIdx   = wordIdx;
    memWrLanes = 4'b0000;
    memWrData  = laneData;
    if (clearing) begin
      memWrIdx   = clrCnt_q;
      memWrLanes = 4'b1111;
      memWrData  = 32'h0000_0000;
    end else if (writeOk) begin
      memWrLanes = laneEn;
    end
  end

  // Byte-lane writable storage; no reset so the array can map onto block RAM.
  always_ff @(posedge clk) begin
    for (int lane = 0; lane < 4; lane++) begin
      if (memWrLanes[lane]) begin
        mem[memWrIdx][lane*8 +: 8] <= memWrData[lane*8 +: 8];
      end
    end
  end

  assign storedWord = mem[wordIdx];
  assign byteSel    = storedWord[byteOff*8 +: 8];
  assign halfSel    = address[1] ? storedWord[31:16] : storedWord[15:0];

  // Load formatting: pick the addressed lanes and extend according to Unsigned.
  always_comb begin
    readData_d = storedWord;
    case (Size)
      SizeByte: readData_d = Unsigned ? {24'h000000, byteSel} : {{24{byteSel[7]}}, byteSel};
      SizeHalf: readData_d = Unsigned ? {16'h0000, halfSel}   : {{16{halfSel[15]}}, halfSel};
      default:  readData_d = storedWord;
    endcase
  end

  assign clrCnt_d = clrCnt_q + 1'b1;

  // Control FSM: clear sequence after reset, then serve requests with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= CLEAR;
      clrCnt_q   <= '0;
      busy_q     <= 1'b1;
      readData_q <= 32'h0000_0000;
      rdValid_q  <= 1'b0;
      memErr_q   <= 1'b0;
    end else begin
      rdValid_q <= 1'b0;
      memErr_q  <= 1'b0;
      case (state_q)
        CLEAR: begin
          clrCnt_q <= clrCnt_d;
          if (clrCnt_q == LastIdx) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        IDLE: begin
          busy_q <= 1'b0;
          if (accessBad) begin
            memErr_q <= 1'b1;
          end else if (readOk) begin
            readData_q <= readData_d;
            rdValid_q  <= 1'b1;
          end
        end
        default: begin
          state_q  <= CLEAR;
          clrCnt_q <= '0;
          busy_q   <= 1'b1;
        end
      endcase
    end
  end

  assign Read_data = readData_q;
  assign rd_valid  = rdValid_q;
  assign busy      = busy_q;
  assign mem_err   = memErr_q;

endmodule
